// File: rtl/can_id_hop_controller.sv
// can_id_hop_controller: CAN ID priority table with arbitrated write, rotate (ID hop), index->ID and ID->index access
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   wr_req_i/wr_addr_i/wr_id_i/wr_ack_o   host write of one table entry
//   hop_req_i/hop_ack_o/hop_cnt_o     rotate table left by one, count of completed hops
//   rx_req_i/rx_prio_i/rx_id_o/rx_ack_o   read ID stored at a priority index
//   tx_req_i/tx_id_i/tx_prio_o/tx_found_o/tx_ack_o   search lowest index holding an ID
//   busy_o                            controller not idle
module can_id_hop_controller #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter int IDW = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_req_i,
  input  logic [AW-1:0]  wr_addr_i,
  input  logic [IDW-1:0] wr_id_i,
  output logic           wr_ack_o,
  input  logic           hop_req_i,
  output logic           hop_ack_o,
  output logic [7:0]     hop_cnt_o,
  input  logic           rx_req_i,
  input  logic [AW-1:0]  rx_prio_i,
  output logic [IDW-1:0] rx_id_o,
  output logic           rx_ack_o,
  input  logic           tx_req_i,
  input  logic [IDW-1:0] tx_id_i,
  output logic [AW-1:0]  tx_prio_o,
  output logic           tx_found_o,
  output logic           tx_ack_o,
  output logic           busy_o
);
  typedef enum logic [1:0] {IDLE, SEARCH, HOP, ACK} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] table_q [DEPTH];
  logic [IDW-1:0] table_d [DEPTH];
  logic [AW-1:0] idx_q, idx_d, nxt;
  logic [IDW-1:0] key_q, key_d, tmp_q, tmp_d, rx_id_q, rx_id_d;
  logic [7:0] hop_cnt_q, hop_cnt_d;
  logic [AW-1:0] tx_prio_q, tx_prio_d;
  logic tx_found_q, tx_found_d;
  logic wr_ack_q, wr_ack_d, hop_ack_q, hop_ack_d, rx_ack_q, rx_ack_d, tx_ack_q, tx_ack_d;
  logic idle, g_wr, g_hop, g_rx, g_tx, last, hit;
  // fixed-priority grant, only evaluated while idle
  assign idle = state_q == IDLE;
  assign g_wr = idle && wr_req_i;
  assign g_hop = idle && !wr_req_i && hop_req_i;
  assign g_rx = idle && !wr_req_i && !hop_req_i && rx_req_i;
  assign g_tx = idle && !wr_req_i && !hop_req_i && !rx_req_i && tx_req_i;
  assign nxt = idx_q + AW'(1);
  assign last = idx_q == AW'(DEPTH - 1);
  assign hit = table_q[idx_q] == key_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= IDW'(i);
      idx_q <= '0;
      key_q <= '0;
      tmp_q <= '0;
      rx_id_q <= '0;
      hop_cnt_q <= '0;
      tx_prio_q <= '0;
      tx_found_q <= 1'b0;
      wr_ack_q <= 1'b0;
      hop_ack_q <= 1'b0;
      rx_ack_q <= 1'b0;
      tx_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      idx_q <= idx_d;
      key_q <= key_d;
      tmp_q <= tmp_d;
      rx_id_q <= rx_id_d;
      hop_cnt_q <= hop_cnt_d;
      tx_prio_q <= tx_prio_d;
      tx_found_q <= tx_found_d;
      wr_ack_q <= wr_ack_d;
      hop_ack_q <= hop_ack_d;
      rx_ack_q <= rx_ack_d;
      tx_ack_q <= tx_ack_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = g_tx ? SEARCH : g_hop ? HOP : (g_wr || g_rx) ? ACK : IDLE;
      SEARCH:  state_d = (hit || last) ? ACK : SEARCH;
      HOP:     state_d = last ? ACK : HOP;
      default: state_d = IDLE;
    endcase
  end
  // datapath and registered acks; the rotation shifts one entry per cycle using tmp for the wrap-around
  always_comb begin
    table_d = table_q;
    idx_d = idx_q;
    key_d = key_q;
    tmp_d = tmp_q;
    rx_id_d = rx_id_q;
    hop_cnt_d = hop_cnt_q;
    tx_prio_d = tx_prio_q;
    tx_found_d = tx_found_q;
    wr_ack_d = g_wr;
    rx_ack_d = g_rx;
    tx_ack_d = state_q == SEARCH && (hit || last);
    hop_ack_d = state_q == HOP && last;
    if (g_wr) table_d[wr_addr_i] = wr_id_i;
    if (g_rx) rx_id_d = table_q[rx_prio_i];
    if (g_tx) begin
      idx_d = '0;
      key_d = tx_id_i;
    end
    if (g_hop) begin
      idx_d = '0;
      tmp_d = table_q[0];
    end
    if (state_q == SEARCH) begin
      idx_d = nxt;
      tx_prio_d = hit ? idx_q : last ? '0 : tx_prio_q;
      tx_found_d = hit ? 1'b1 : last ? 1'b0 : tx_found_q;
    end
    if (state_q == HOP) begin
      table_d[idx_q] = last ? tmp_q : table_q[nxt];
      idx_d = nxt;
      hop_cnt_d = last ? hop_cnt_q + 8'd1 : hop_cnt_q;
    end
  end
  always_comb begin
    busy_o = state_q != IDLE;
    wr_ack_o = wr_ack_q;
    hop_ack_o = hop_ack_q;
    rx_ack_o = rx_ack_q;
    tx_ack_o = tx_ack_q;
    hop_cnt_o = hop_cnt_q;
    rx_id_o = rx_id_q;
    tx_prio_o = tx_prio_q;
    tx_found_o = tx_found_q;
  end
endmodule

// File: tb/tb_can_id_hop_controller.sv
// tb_can_id_hop_controller: directed table-driven bench for can_id_hop_controller
module tb_can_id_hop_controller;
  localparam int DEPTH = 16, AW = 4, IDW = 11;
  logic clk = 1'b0, rst = 1'b0;
  logic wr_req = 1'b0, hop_req = 1'b0, rx_req = 1'b0, tx_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rx_prio = '0;
  logic [IDW-1:0] wr_id = '0, tx_id = '0;
  logic wr_ack, hop_ack, rx_ack, tx_ack, tx_found, busy;
  logic [7:0] hop_cnt;
  logic [IDW-1:0] rx_id;
  logic [AW-1:0] tx_prio;
  int checks = 0, errors = 0, n;
  typedef enum int {WR, HOP, RX, TX} op_t;
  typedef struct {
    op_t op;
    logic [AW-1:0] a;
    logic [IDW-1:0] id;
    int val;
    int found;
    int n;
  } vec_t;
  vec_t v [12];
  can_id_hop_controller #(.DEPTH(DEPTH), .AW(AW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_id_i(wr_id), .wr_ack_o(wr_ack),
    .hop_req_i(hop_req), .hop_ack_o(hop_ack), .hop_cnt_o(hop_cnt),
    .rx_req_i(rx_req), .rx_prio_i(rx_prio), .rx_id_o(rx_id), .rx_ack_o(rx_ack),
    .tx_req_i(tx_req), .tx_id_i(tx_id), .tx_prio_o(tx_prio), .tx_found_o(tx_found), .tx_ack_o(tx_ack),
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  function automatic logic ack_of(input op_t op);
    return op == WR ? wr_ack : op == HOP ? hop_ack : op == RX ? rx_ack : tx_ack;
  endfunction
  // raise one request, scramble its operands after the grant edge, count edges until its ack is seen
  task automatic run(input op_t op, input logic [AW-1:0] a, input logic [IDW-1:0] id, output int cnt);
    cnt = 0;
    case (op)
      WR: begin wr_addr = a; wr_id = id; wr_req = 1'b1; end
      HOP: hop_req = 1'b1;
      RX: begin rx_prio = a; rx_req = 1'b1; end
      default: begin tx_id = id; tx_req = 1'b1; end
    endcase
    do begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        wr_addr = ~a; wr_id = ~id; rx_prio = ~a; tx_id = ~id;
      end
    end while (!ack_of(op) && cnt < 50);
    wr_req = 1'b0; hop_req = 1'b0; rx_req = 1'b0; tx_req = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    v[0]  = '{RX,  4'd5,  11'h000, 5,     0, 1};
    v[1]  = '{TX,  4'd0,  11'h007, 7,     1, 9};
    v[2]  = '{TX,  4'd0,  11'h7FF, 0,     0, 17};
    v[3]  = '{WR,  4'd3,  11'h123, 0,     0, 1};
    v[4]  = '{TX,  4'd0,  11'h123, 3,     1, 5};
    v[5]  = '{TX,  4'd0,  11'h003, 0,     0, 17};
    v[6]  = '{HOP, 4'd0,  11'h000, 1,     0, 17};
    v[7]  = '{RX,  4'd0,  11'h000, 1,     0, 1};
    v[8]  = '{RX,  4'd15, 11'h000, 0,     0, 1};
    v[9]  = '{RX,  4'd2,  11'h000, 'h123, 0, 1};
    v[10] = '{TX,  4'd0,  11'h123, 2,     1, 4};
    v[11] = '{TX,  4'd0,  11'h000, 15,    1, 17};
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({wr_ack, hop_ack, rx_ack, tx_ack, tx_found, busy, hop_cnt, rx_id, tx_prio}), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run(v[i].op, v[i].a, v[i].id, n);
      chk($sformatf("v%0d_latency", i), n, v[i].n);
      chk($sformatf("v%0d_busy_in_ack", i), int'(busy), 1);
      case (v[i].op)
        RX: chk($sformatf("v%0d_rx_id", i), int'(rx_id), v[i].val);
        TX: begin
          chk($sformatf("v%0d_tx_prio", i), int'(tx_prio), v[i].val);
          chk($sformatf("v%0d_tx_found", i), int'(tx_found), v[i].found);
        end
        HOP: chk($sformatf("v%0d_hop_cnt", i), int'(hop_cnt), v[i].val);
        default: ;
      endcase
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy_idle", i), int'(busy), 0);
      chk($sformatf("v%0d_acks_low", i), int'({wr_ack, hop_ack, rx_ack, tx_ack}), 0);
    end
    hop_req = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midhop_busy", int'(busy), 1);
    rst = 1'b1;
    hop_req = 1'b0;
    #2;
    chk("midhop_rst_busy", int'(busy), 0);
    chk("midhop_rst_cnt", int'(hop_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (hop_ack || busy) begin
        chk("midhop_no_ack", int'({hop_ack, busy}), 0);
        break;
      end
    end
    foreach (v[i]) if (i < 4) begin
      run(RX, AW'(i), '0, n);
      chk($sformatf("midhop_identity_%0d", i), int'(rx_id), i);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 256; i++) begin
      run(HOP, '0, '0, n);
      if (n >= 50) chk("hop_loop_timeout", n, 17);
      if (i == 254) chk("hop_cnt_255", int'(hop_cnt), 255);
      @(posedge clk); #1;
    end
    chk("hop_cnt_wrap", int'(hop_cnt), 0);
    for (int i = 0; i < DEPTH; i++) begin
      run(RX, AW'(i), '0, n);
      chk($sformatf("identity_after_256_%0d", i), int'(rx_id), i);
      @(posedge clk); #1;
    end
    wr_addr = '0; wr_id = 11'h055; tx_id = 11'h055;
    wr_req = 1'b1; tx_req = 1'b1;
    @(posedge clk); #1;
    chk("wrtx_wr_ack_first", int'({wr_ack, tx_ack}), 2);
    wr_req = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tx_ack && n < 50);
    tx_req = 1'b0;
    chk("wrtx_tx_latency", n, 3);
    chk("wrtx_tx_prio", int'(tx_prio), 0);
    chk("wrtx_tx_found", int'(tx_found), 1);
    @(posedge clk); #1;
    chk("wrtx_idle", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
